// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller feeding a UART transmitter.
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   wr, w_data      : byte push strobe and data from the core
//   full, empty     : FIFO occupancy flags (combinational from count)
//   count           : stored byte count, 0..2^ADDR_WIDTH
//   overflow        : sticky, set when a push is dropped on full
//   tx_start, din   : one-cycle launch pulse and held byte to transmitter
//   tx_active       : transmitter busy flag
//   tx_done         : transmitter one-cycle completion pulse
`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] din,
    input  logic                  tx_active,
    input  logic                  tx_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_ACTIVE,
        S_WAIT_DONE
    } state_t;

    state_t state, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  push;
    logic                  launch;

    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // full is evaluated from the registered count, so a push coinciding
    // with a launch pop while full is still dropped.
    assign push = wr && !full;

    // Launch decisions use the registered count, so a byte written into
    // an empty FIFO launches one edge later. Requiring tx_active low in
    // idle also lets a frame in flight across a reset finish undisturbed.
    always_comb begin
        state_d = state;
        launch  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty && !tx_active) begin
                    launch  = 1'b1;
                    state_d = S_WAIT_ACTIVE;
                end
            end
            S_WAIT_ACTIVE: begin
                if (tx_active) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Storage carries no reset; contents are discarded by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (launch) begin
                rp <= rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            unique case ({push, launch})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr && full) begin
            overflow <= 1'b1;
        end
    end

    // din holds the last launched byte until the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            din      <= '0;
        end else begin
            tx_start <= launch;
            if (launch) begin
                din <= mem[rp];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural transmitter
// model, a launch scoreboard, a fill table and multi-cycle sequences.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] w_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_active;
    logic       tx_done;

    uart_tx_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .w_data   (w_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .din      (din),
        .tx_active(tx_active),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sb[$];
    logic       busy = 1'b0;
    logic       hold = 1'b0;
    logic       prev_start = 1'b0;
    int         bits = 0;
    int         frame_len = 4;
    int         launches = 0;

    assign tx_active = busy | hold;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model plus launch monitor; no reset, like the real one.
    initial tx_done = 1'b0;
    always @(negedge clk) begin
        logic [7:0] exp;
        tx_done = 1'b0;
        if (tx_start === 1'b1) begin
            n_cmp++;
            if (busy || hold || prev_start) begin
                n_err++;
                $display("FAIL launch_while_busy: busy=%0b start_prev=%0b",
                         busy, prev_start);
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_launch: din=%0h expected none", din);
            end else begin
                exp = sb.pop_front();
                if (din !== exp) begin
                    n_err++;
                    $display("FAIL launch_data: din=%0h expected %0h", din, exp);
                end
            end
            launches++;
            busy = 1'b1;
            bits = frame_len;
        end else if (busy) begin
            if (bits == 0) begin
                busy    = 1'b0;
                tx_done = 1'b1;
            end else begin
                bits--;
            end
        end
        prev_start = tx_start;
        n_cmp++;
        if (count > 5'd16) begin
            n_err++;
            $display("FAIL count_range: count=%0d expected <=16", count);
        end
    end

    task automatic write_byte(input logic [7:0] b);
        wr     = 1'b1;
        w_data = b;
        sb.push_back(b);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c = 0;
        while ((sb.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (sb.size() != 0 || busy) begin
            n_err++;
            $display("FAIL %s: timeout pending=%0d expected 0", name, sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic [4:0] exp_count;
        logic       exp_full;
        logic       exp_empty;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int l0;
        int c;
        for (int i = 0; i < 17; i++) begin
            tbl[i] = '{1'b1, 8'(8'h30 + i),
                       5'((i < 16) ? i + 1 : 16),
                       (i >= 15), 1'b0, (i == 16)};
        end
        tbl[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b1};

        rst_n  = 1'b0;
        wr     = 1'b0;
        w_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_din", 32'(din), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: launch two edges after the write.
        wr     = 1'b1;
        w_data = 8'hA5;
        sb.push_back(8'hA5);
        @(negedge clk);
        wr = 1'b0;
        chk("single_count1", 32'(count), 32'd1);
        chk("single_no_early_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        chk("single_start", 32'(tx_start), 32'd1);
        chk("single_din", 32'(din), 32'hA5);
        chk("single_count0", 32'(count), 32'd0);
        @(negedge clk);
        chk("single_pulse_width", 32'(tx_start), 32'd0);
        chk("single_din_hold", 32'(din), 32'hA5);
        wait_drain(200, "single_drain");

        // Burst of five back-to-back writes.
        l0 = launches;
        for (int i = 1; i <= 5; i++) begin
            wr     = 1'b1;
            w_data = 8'(i);
            sb.push_back(8'(i));
            @(negedge clk);
        end
        wr = 1'b0;
        wait_drain(400, "burst_drain");
        chk("burst_launches", 32'(launches - l0), 32'd5);

        // Push coinciding with a launch pop at count 3.
        hold = 1'b1;
        write_byte(8'hB1);
        write_byte(8'hB2);
        write_byte(8'hB3);
        chk("simul_pre_count", 32'(count), 32'd3);
        hold   = 1'b0;
        wr     = 1'b1;
        w_data = 8'hB4;
        sb.push_back(8'hB4);
        @(negedge clk);
        wr = 1'b0;
        chk("simul_count", 32'(count), 32'd3);
        chk("simul_start", 32'(tx_start), 32'd1);
        chk("simul_din_oldest", 32'(din), 32'hB1);
        wait_drain(400, "simul_drain");

        // Fill with transmitter held busy; 17th byte is dropped.
        hold = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr     = tbl[i].wr;
            w_data = tbl[i].data;
            if (tbl[i].wr && i < 16) sb.push_back(tbl[i].data);
            @(negedge clk);
            wr = 1'b0;
            chk($sformatf("fill_count_%0d", i), 32'(count),
                32'(tbl[i].exp_count));
            chk($sformatf("fill_full_%0d", i), 32'(full),
                32'(tbl[i].exp_full));
            chk($sformatf("fill_empty_%0d", i), 32'(empty),
                32'(tbl[i].exp_empty));
            chk($sformatf("fill_ovf_%0d", i), 32'(overflow),
                32'(tbl[i].exp_ovf));
        end
        hold = 1'b0;
        wait_drain(1000, "fill_drain");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("drain_empty", 32'(empty), 32'd1);

        // Reset mid-frame: in-flight frame must finish before relaunch.
        frame_len = 12;
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        c = 0;
        while (!busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_start", 32'(tx_start), 32'd0);
        chk("arst_din", 32'(din), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_still_busy", 32'(busy), 32'd1);
        write_byte(8'h5A);
        wait_drain(400, "post_reset_drain");
        frame_len = 4;

        // Wrap-around with random gaps; keep pending below depth.
        for (int i = 0; i < 40; i++) begin
            c = 0;
            while (sb.size() >= 12 && c < 200) begin
                @(negedge clk);
                c++;
            end
            repeat ($urandom_range(0, 6)) @(negedge clk);
            write_byte(8'($urandom_range(0, 255)));
        end
        wait_drain(2000, "wrap_drain");
        chk("wrap_no_overflow", 32'(overflow), 32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
